asic_boot_pad_top: RTL and testbench

- Reduced chip top for the ecos test chip: pad-level wrapper that routes one selectable IP core onto the IO pads.
- ip_sel = 1 selects the built-in boot streamer. After reset it reads BOOT_BYTES bytes from an external N25Q-class SPI NOR flash on chip-select 0, using a standard READ 0x03 command. It then transmits those bytes on UART TX.
- All other ip_sel codes park the pads idle.

---
 rtl/asic_boot_pkg.sv | 31 +++
 rtl/asic_boot_pad_top_uart_tx_8n1.sv | 61 ++++++
 rtl/asic_boot_pad_top.sv | 196 +++++++++++++++++++
 tb/tb_asic_boot_pad_top.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/asic_boot_pkg.sv
// Shared constants for the ecos reduced chip top: FSM encodings, flash command,
// IP select code and pad map.
package asic_boot_pkg;

  typedef logic [2:0] boot_state_t;

  localparam logic [2:0] ST_WAIT       = 3'd0;
  localparam logic [2:0] ST_CS_SETUP   = 3'd1;
  localparam logic [2:0] ST_SHIFT_CMD  = 3'd2;
  localparam logic [2:0] ST_SHIFT_DATA = 3'd3;
  localparam logic [2:0] ST_CS_HOLD    = 3'd4;
  localparam logic [2:0] ST_UART_SEND  = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [2:0] IP_SEL_BOOT  = 3'd1;

  localparam int PAD_UART_RX   = 0;
  localparam int PAD_UART_TX   = 1;
  localparam int PAD_SPI_SCLK  = 2;
  localparam int PAD_SPI_CS0   = 3;
  localparam int PAD_SPI_CS1   = 4;
  localparam int PAD_BOOT_DONE = 5;
  localparam int PAD_SPI_MOSI  = 11;
  localparam int PAD_SPI_MISO  = 12;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/asic_boot_pad_top_uart_tx_8n1.sv
// 8N1 UART transmitter. busy drops during the last stop-bit clock so a new
// start in that cycle produces a back-to-back frame with no idle gap.
module uart_tx_8n1
  import asic_boot_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CNT_W = clog2_min1(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic             active_reg;
  logic [8:0]       frame_reg;
  logic [3:0]       bit_idx_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic             tx_reg;
  logic             frame_end;

  assign frame_end = active_reg && (bit_idx_reg == 4'd9) && (baud_cnt_reg == CNT_LAST);
  assign busy      = active_reg && !frame_end;
  assign tx        = tx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg   <= 1'b0;
      frame_reg    <= 9'h1FF;
      bit_idx_reg  <= 4'd0;
      baud_cnt_reg <= '0;
      tx_reg       <= 1'b1;
    end else if (start && !busy) begin
      active_reg   <= 1'b1;
      frame_reg    <= {1'b1, data};
      bit_idx_reg  <= 4'd0;
      baud_cnt_reg <= '0;
      tx_reg       <= 1'b0;
    end else if (active_reg) begin
      if (baud_cnt_reg == CNT_LAST) begin
        baud_cnt_reg <= '0;
        if (bit_idx_reg == 4'd9) begin
          active_reg <= 1'b0;
          tx_reg     <= 1'b1;
        end else begin
          // frame_reg holds the remaining data bits then the stop bit, LSB first
          bit_idx_reg <= bit_idx_reg + 4'd1;
          tx_reg      <= frame_reg[0];
          frame_reg   <= {1'b1, frame_reg[8:1]};
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/asic_boot_pad_top.sv
// Reduced ecos chip top: ip_sel=1 streams BOOT_BYTES from SPI NOR (READ 0x03)
// out of the UART; any other latched ip_sel leaves the pads idle.
module asic_boot_pad_top
  import asic_boot_pkg::*;
#(
  parameter int          POWERUP_CYCLES = 256,
  parameter int          SPI_DIV        = 4,
  parameter int          BAUD_DIV       = 27,
  parameter int          BOOT_BYTES     = 16,
  parameter logic [23:0] BOOT_ADDR      = 24'h000000
) (
  input  logic       r_osc_clk_25m,
  input  logic       r_ext_rst_n,
  input  logic [2:0] ip_sel,
  output logic       sys_clk_o,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       spi_sclk,
  output logic [1:0] spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       boot_done
);

  localparam int DATA_BITS = 8 * BOOT_BYTES;
  localparam int WAIT_W    = clog2_min1(POWERUP_CYCLES);
  localparam int DIV_W     = clog2_min1(SPI_DIV);
  localparam int BIT_W     = clog2_min1(DATA_BITS + 32);
  localparam int IDX_W     = clog2_min1(BOOT_BYTES);
  localparam int TXI_W     = clog2_min1(BOOT_BYTES + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POWERUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SPI_DIV - 1);
  localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(SPI_DIV / 2 - 1);
  localparam logic [BIT_W-1:0]  CMD_LAST  = BIT_W'(31);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [TXI_W-1:0]  TX_END    = TXI_W'(BOOT_BYTES);
  localparam logic [31:0]       CMD_WORD  = {SPI_CMD_READ, BOOT_ADDR};

  boot_state_t       state_reg;
  logic              sel_valid_reg;
  logic [2:0]        sel_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [31:0]       cmd_sr_reg;
  logic [7:0]        rx_sr_reg;
  logic [TXI_W-1:0]  tx_idx_reg;
  logic              sclk_reg;
  logic              cs0_n_reg;
  logic              mosi_reg;
  logic              boot_done_reg;
  logic [7:0]        buf_mem [BOOT_BYTES];

  logic boot_en;
  logic uart_start;
  logic uart_busy;
  logic uart_line;
  logic unused_pads;

  assign boot_en     = sel_valid_reg && (sel_reg == IP_SEL_BOOT);
  assign uart_start  = (state_reg == ST_UART_SEND) && !uart_busy && (tx_idx_reg != TX_END);
  assign unused_pads = uart_rx;

  assign sys_clk_o = r_osc_clk_25m;
  assign spi_sclk  = sclk_reg;
  assign spi_cs_n  = {1'b1, cs0_n_reg};
  assign spi_mosi  = mosi_reg;
  assign uart_tx   = uart_line;
  assign boot_done = boot_done_reg;

  // SCLK period: low half then high half; MISO captured as SCLK rises,
  // MOSI advanced as SCLK falls.
  always_ff @(posedge r_osc_clk_25m or negedge r_ext_rst_n) begin
    if (!r_ext_rst_n) begin
      state_reg     <= ST_WAIT;
      sel_valid_reg <= 1'b0;
      sel_reg       <= 3'd0;
      wait_cnt_reg  <= '0;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      cmd_sr_reg    <= '0;
      rx_sr_reg     <= '0;
      tx_idx_reg    <= '0;
      sclk_reg      <= 1'b0;
      cs0_n_reg     <= 1'b1;
      mosi_reg      <= 1'b0;
      boot_done_reg <= 1'b0;
    end else begin
      if (!sel_valid_reg) begin
        sel_valid_reg <= 1'b1;
        sel_reg       <= ip_sel;
      end
      case (state_reg)
        ST_WAIT: begin
          if (wait_cnt_reg != WAIT_LAST) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end else if (boot_en) begin
            state_reg   <= ST_CS_SETUP;
            cs0_n_reg   <= 1'b0;
            cmd_sr_reg  <= CMD_WORD;
            mosi_reg    <= CMD_WORD[31];
            div_cnt_reg <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (div_cnt_reg == HALF_LAST) begin
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= ST_SHIFT_CMD;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        ST_SHIFT_CMD: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            cmd_sr_reg  <= {cmd_sr_reg[30:0], 1'b0};
            if (bit_cnt_reg == CMD_LAST) begin
              mosi_reg    <= 1'b0;
              bit_cnt_reg <= '0;
              state_reg   <= ST_SHIFT_DATA;
            end else begin
              mosi_reg    <= cmd_sr_reg[30];
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
            if (div_cnt_reg == HALF_LAST) sclk_reg <= 1'b1;
          end
        end
        ST_SHIFT_DATA: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            if (bit_cnt_reg == DATA_LAST) begin
              bit_cnt_reg <= '0;
              state_reg   <= ST_CS_HOLD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
            if (div_cnt_reg == HALF_LAST) begin
              sclk_reg  <= 1'b1;
              rx_sr_reg <= {rx_sr_reg[6:0], spi_miso};
            end
          end
        end
        ST_CS_HOLD: begin
          if (div_cnt_reg == HALF_LAST) begin
            div_cnt_reg <= '0;
            cs0_n_reg   <= 1'b1;
            tx_idx_reg  <= '0;
            state_reg   <= ST_UART_SEND;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        ST_UART_SEND: begin
          if (!uart_busy) begin
            if (tx_idx_reg != TX_END) begin
              tx_idx_reg <= tx_idx_reg + 1'b1;
            end else begin
              boot_done_reg <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
        end
        default: state_reg <= ST_WAIT;
      endcase
    end
  end

  // Byte complete on the falling edge that ends its 8th bit.
  always_ff @(posedge r_osc_clk_25m) begin
    if ((state_reg == ST_SHIFT_DATA) && (div_cnt_reg == DIV_LAST) && (bit_cnt_reg[2:0] == 3'b111)) begin
      buf_mem[bit_cnt_reg[IDX_W+2:3]] <= rx_sr_reg;
    end
  end

  uart_tx_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk  (r_osc_clk_25m),
    .rst_n(r_ext_rst_n),
    .start(uart_start),
    .data (buf_mem[tx_idx_reg[IDX_W-1:0]]),
    .busy (uart_busy),
    .tx   (uart_line)
  );

endmodule

// File: tb/tb_asic_boot_pad_top.sv
// Directed bench for asic_boot_pad_top with an N25Q-style READ flash model and
// a UART frame decoder.
module tb_asic_boot_pad_top;

  localparam int POWERUP     = 256;
  localparam int SPI_DIV     = 4;
  localparam int BAUD        = 27;
  localparam int NBYTES      = 16;
  localparam int SCLK_PULSES = 160;
  localparam int CS_LOW_CLKS = 644;
  localparam int FRAME_CLKS  = 270;
  localparam int LIMIT_500US = 12500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ip_sel = 3'd0;
  logic       uart_rx = 1'b1;
  logic       spi_miso = 1'b0;
  logic       sys_clk_o;
  logic       uart_tx;
  logic       spi_sclk;
  logic [1:0] spi_cs_n;
  logic       spi_mosi;
  logic       boot_done;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int base = 0;
  int rx_base = 0;
  int sclk_base = 0;
  int bad_base = 0;
  int sclk_cnt = 0;
  int cs_fall_cyc = -100000;
  int cs_rise_cyc = -100000;
  int done_cyc = -100000;
  int idle_viol = 0;
  int cs1_viol = 0;
  logic mon_idle = 1'b0;

  logic [7:0] flash_mem [256];
  int         fl_cnt = 0;
  logic [31:0] fl_cmd = '0;

  logic [7:0] rx_byte_q [$];
  int         rx_start_q [$];
  int         rx_bad = 0;

  asic_boot_pad_top #(
    .POWERUP_CYCLES(POWERUP),
    .SPI_DIV       (SPI_DIV),
    .BAUD_DIV      (BAUD),
    .BOOT_BYTES    (NBYTES),
    .BOOT_ADDR     (24'h000000)
  ) dut (
    .r_osc_clk_25m(clk),
    .r_ext_rst_n  (rst_n),
    .ip_sel       (ip_sel),
    .sys_clk_o    (sys_clk_o),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .boot_done    (boot_done)
  );

  always #20 clk = ~clk;

  always @(negedge clk) cyc <= cyc + 1;
  always @(posedge spi_sclk) sclk_cnt <= sclk_cnt + 1;
  always @(negedge spi_cs_n[0]) cs_fall_cyc = cyc;
  always @(posedge spi_cs_n[0]) cs_rise_cyc = cyc;
  always @(posedge boot_done) done_cyc = cyc;

  always @(negedge clk) begin
    if (mon_idle && !(spi_cs_n === 2'b11 && spi_sclk === 1'b0 && spi_mosi === 1'b0 &&
                      uart_tx === 1'b1 && boot_done === 1'b0))
      idle_viol <= idle_viol + 1;
    if (spi_cs_n[1] !== 1'b1) cs1_viol <= cs1_viol + 1;
  end

  // Flash: mode 0, command/address on rising SCLK, data out on falling SCLK.
  initial begin : flash_model
    logic [7:0] fbyte;
    int         boff;
    forever begin
      @(negedge spi_cs_n[0]);
      fl_cnt = 0;
      fl_cmd = '0;
      while (spi_cs_n[0] === 1'b0) begin
        @(posedge spi_sclk or posedge spi_cs_n[0]);
        if (spi_cs_n[0] === 1'b0) begin
          if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], spi_mosi};
          fl_cnt++;
          @(negedge spi_sclk or posedge spi_cs_n[0]);
          if (spi_cs_n[0] === 1'b0 && fl_cnt >= 32) begin
            boff     = fl_cnt - 32;
            fbyte    = flash_mem[(int'(fl_cmd[23:0]) + boff / 8) % 256];
            spi_miso = fbyte[7 - (boff % 8)];
          end
        end
      end
    end
  end

  initial begin : uart_decoder
    logic [7:0] b;
    int         st;
    logic       ok;
    forever begin
      @(negedge uart_tx);
      st = cyc;
      ok = 1'b1;
      repeat (BAUD / 2) @(posedge clk);
      #1;
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(posedge clk);
        #1;
        b[i] = uart_tx;
      end
      repeat (BAUD) @(posedge clk);
      #1;
      if (uart_tx !== 1'b1) ok = 1'b0;
      if (!ok) rx_bad++;
      rx_byte_q.push_back(b);
      rx_start_q.push_back(st);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset_release(input logic [2:0] sel);
    rst_n  = 1'b0;
    ip_sel = sel;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    base      = cyc;
    rx_base   = rx_byte_q.size();
    sclk_base = sclk_cnt;
    bad_base  = rx_bad;
  endtask

  task automatic check_run(input string tag, output int done_edge);
    int n;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (boot_done === 1'b1) break;
    end
    chk({tag, "_done_timeout"}, 32'(boot_done), 32'd1);
    repeat (5) @(negedge clk);
    chk({tag, "_cs_fall_edge"}, cs_fall_cyc - base + 1, POWERUP);
    chk({tag, "_cs_low_clks"}, cs_rise_cyc - cs_fall_cyc, CS_LOW_CLKS);
    chk({tag, "_sclk_pulses"}, sclk_cnt - sclk_base, SCLK_PULSES);
    chk({tag, "_cmd_word"}, fl_cmd, 32'h0300_0000);
    chk({tag, "_pads_after"}, 32'({spi_cs_n, spi_sclk, spi_mosi, uart_tx}), 32'b11001);
    n = rx_byte_q.size() - rx_base;
    chk({tag, "_frames"}, n, NBYTES);
    chk({tag, "_bad_frames"}, rx_bad - bad_base, 0);
    for (int i = 0; i < n && i < NBYTES; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_byte_q[rx_base + i]), 32'(flash_mem[i]));
    for (int i = 1; i < n; i++)
      chk($sformatf("%s_frame%0d_len", tag, i - 1),
          rx_start_q[rx_base + i] - rx_start_q[rx_base + i - 1], FRAME_CLKS);
    if (n > 0)
      chk({tag, "_done_after_stop"}, done_cyc - rx_start_q[rx_base + n - 1], FRAME_CLKS);
    done_edge = done_cyc - base + 1;
    chk({tag, "_done_before_500us"}, 32'(done_edge < LIMIT_500US), 32'd1);
    $display("run %s: %0d frames, boot_done at clock %0d", tag, n, done_edge);
  endtask

  initial begin : stimulus
    int v0;
    int d2, d4, d5, d6;

    for (int i = 0; i < 256; i++) flash_mem[i] = 8'(i);

    // 1: reset values, then ip_sel=0 keeps pads idle for 500 us
    rst_n  = 1'b0;
    ip_sel = 3'd0;
    #30;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd3);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_done", 32'(boot_done), 32'd0);
    chk("rst_sysclk", 32'(sys_clk_o), 32'(clk));
    do_reset_release(3'd0);
    mon_idle = 1'b1;
    v0 = idle_viol;
    @(posedge clk);
    #1;
    chk("sysclk_high", 32'(sys_clk_o), 32'd1);
    #20;
    chk("sysclk_low", 32'(sys_clk_o), 32'd0);
    repeat (LIMIT_500US) @(negedge clk);
    #1;
    mon_idle = 1'b0;
    chk("sel0_idle_viol", idle_viol - v0, 0);
    $display("test sel0: idle for %0d clocks", LIMIT_500US);

    // 2/3: boot with flash 0x00..0x0F
    do_reset_release(3'd1);
    check_run("boot", d2);

    // 4: MSB-first capture / LSB-first send
    flash_mem[0] = 8'hA5;
    flash_mem[1] = 8'h3C;
    do_reset_release(3'd1);
    check_run("pattern", d4);

    // 5: asynchronous reset during SHIFT_DATA, then full restart
    do_reset_release(3'd1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sclk_cnt - sclk_base >= 60) break;
    end
    chk("abort_in_data_cs", 32'(spi_cs_n), 32'd2);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(spi_cs_n), 32'd3);
    chk("abort_sclk", 32'(spi_sclk), 32'd0);
    chk("abort_tx_mosi", 32'({uart_tx, spi_mosi}), 32'b10);
    $display("test abort: async reset at %0t", $time);
    do_reset_release(3'd1);
    check_run("restart", d5);
    chk("restart_same_timing", d5, d4);

    // 6a: ip_sel 1->0 after latch, boot still completes
    do_reset_release(3'd1);
    repeat (10) @(negedge clk);
    ip_sel = 3'd0;
    check_run("sel_1to0", d6);

    // 6b: ip_sel 0->1 after latch, pads stay idle
    do_reset_release(3'd0);
    repeat (10) @(negedge clk);
    ip_sel = 3'd1;
    #1;
    mon_idle = 1'b1;
    v0 = idle_viol;
    repeat (8000) @(negedge clk);
    #1;
    mon_idle = 1'b0;
    chk("sel_0to1_idle_viol", idle_viol - v0, 0);
    chk("sel_0to1_done", 32'(boot_done), 32'd0);
    $display("test sel 0->1: idle for 8000 clocks");

    chk("cs1_always_high", cs1_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
